// File: rtl/ex_multicycle_seq.sv
// EX-stage sequencer for the multi-cycle vector ops VDIV, VMOD and VSQRT.
// Walks the lanes MSB-first through a shared iterative div/mod/sqrt unit.
module ex_multicycle_seq #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        instr_valid,
    input  logic [31:0] ID_EX_Instr,
    input  logic [63:0] op_a,
    input  logic [63:0] op_b,
    output logic        stall,
    output logic        mc_start,
    output logic [1:0]  mc_op,
    output logic [1:0]  mc_width,
    output logic [63:0] mc_a,
    output logic [63:0] mc_b,
    input  logic        mc_done,
    input  logic [63:0] mc_result,
    output logic        seq_valid,
    output logic [63:0] seq_result,
    output logic        dz_flag,
    output logic        to_flag
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT,
        S_NEXT,
        S_DONE
    } state_t;

    localparam int TO_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam bit TO_EN = (TIMEOUT > 0);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    state_t          state;
    logic [63:0]     a_q;
    logic [63:0]     b_q;
    logic [1:0]      op_q;
    logic [1:0]      ww_q;
    logic [2:0]      lane;
    logic [TO_W-1:0] to_cnt;

    logic            is_mc;
    logic [1:0]      dec_op;
    logic [63:0]     lane_mask;
    logic [6:0]      shamt;
    logic [2:0]      last_lane;
    logic [63:0]     lane_a;
    logic [63:0]     lane_b;
    logic            zero_div;
    logic [63:0]     lane_val;
    logic [63:0]     merged;
    logic            unused_instr;

    // ISA numbers bits MSB=0: opcode is [31:26], WW [7:6], func [5:0] here
    always_comb begin
        is_mc  = 1'b0;
        dec_op = 2'b00;
        if (ID_EX_Instr[31:26] == 6'b101010) begin
            case (ID_EX_Instr[5:0])
                6'b001110: begin is_mc = 1'b1; dec_op = 2'b00; end
                6'b001111: begin is_mc = 1'b1; dec_op = 2'b01; end
                6'b010010: begin is_mc = 1'b1; dec_op = 2'b10; end
                default:   begin is_mc = 1'b0; dec_op = 2'b00; end
            endcase
        end
    end

    assign unused_instr = ^ID_EX_Instr[25:8];

    always_comb begin
        unique case (ww_q)
            2'b00:   lane_mask = 64'h0000_0000_0000_00ff;
            2'b01:   lane_mask = 64'h0000_0000_0000_ffff;
            2'b10:   lane_mask = 64'h0000_0000_ffff_ffff;
            default: lane_mask = 64'hffff_ffff_ffff_ffff;
        endcase
    end

    // Lane 0 sits in the most significant LW bits
    assign last_lane = 3'd7 >> ww_q;
    assign shamt     = 7'd64 - (({4'd0, lane} + 7'd1) << (7'd3 + {5'd0, ww_q}));
    assign lane_a    = (a_q >> shamt) & lane_mask;
    assign lane_b    = (b_q >> shamt) & lane_mask;
    assign zero_div  = (op_q != 2'b10) && (lane_b == 64'd0);

    always_comb begin
        lane_val = lane_mask;
        if (state == S_WAIT && mc_done)
            lane_val = mc_result;
        else if (state == S_LAUNCH && op_q == 2'b01)
            lane_val = lane_a;
    end

    assign merged = (seq_result & ~(lane_mask << shamt))
                  | ((lane_val & lane_mask) << shamt);

    assign stall = !reset &&
                   ((state == S_IDLE && instr_valid && is_mc) ||
                    state == S_LAUNCH || state == S_WAIT ||
                    state == S_NEXT);
    assign mc_start  = !reset && state == S_LAUNCH && !zero_div;
    assign seq_valid = (state == S_DONE);
    assign mc_op     = op_q;
    assign mc_width  = ww_q;
    assign mc_a      = lane_a;
    assign mc_b      = lane_b;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            a_q        <= '0;
            b_q        <= '0;
            op_q       <= '0;
            ww_q       <= '0;
            lane       <= '0;
            to_cnt     <= '0;
            seq_result <= '0;
            dz_flag    <= 1'b0;
            to_flag    <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (instr_valid && is_mc) begin
                        a_q        <= op_a;
                        b_q        <= op_b;
                        op_q       <= dec_op;
                        ww_q       <= ID_EX_Instr[7:6];
                        lane       <= '0;
                        seq_result <= '0;
                        dz_flag    <= 1'b0;
                        to_flag    <= 1'b0;
                        state      <= S_LAUNCH;
                    end
                end
                S_LAUNCH: begin
                    if (zero_div) begin
                        seq_result <= merged;
                        dz_flag    <= 1'b1;
                        state      <= S_NEXT;
                    end else begin
                        to_cnt <= '0;
                        state  <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (mc_done) begin
                        seq_result <= merged;
                        state      <= S_NEXT;
                    end else if (TO_EN && to_cnt == TO_LAST) begin
                        seq_result <= merged;
                        to_flag    <= 1'b1;
                        state      <= S_NEXT;
                    end else begin
                        to_cnt <= to_cnt + TO_W'(1);
                    end
                end
                S_NEXT: begin
                    if (lane == last_lane) begin
                        state <= S_DONE;
                    end else begin
                        lane  <= lane + 3'd1;
                        state <= S_LAUNCH;
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ex_multicycle_seq.sv
// Directed bench for ex_multicycle_seq with a behavioural iterative unit.
// Vector table plus hand-written reset and non-multi-cycle sequences.
module tb_ex_multicycle_seq;

    localparam logic [5:0] OPC_V  = 6'b101010;
    localparam logic [5:0] F_DIV  = 6'b001110;
    localparam logic [5:0] F_MOD  = 6'b001111;
    localparam logic [5:0] F_SQRT = 6'b010010;

    typedef struct {
        logic [31:0] instr;
        logic [63:0] a;
        logic [63:0] b;
        int          lat;
        logic [63:0] exp_res;
        int          exp_starts;
        logic        exp_dz;
        logic        exp_to;
        int          exp_cyc;
        logic [1:0]  exp_op;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        instr_valid;
    logic [31:0] ID_EX_Instr;
    logic [63:0] op_a;
    logic [63:0] op_b;
    logic        stall;
    logic        mc_start;
    logic [1:0]  mc_op;
    logic [1:0]  mc_width;
    logic [63:0] mc_a;
    logic [63:0] mc_b;
    logic        mc_done = 1'b0;
    logic [63:0] mc_result = 64'd0;
    logic        seq_valid;
    logic [63:0] seq_result;
    logic        dz_flag;
    logic        to_flag;

    int n_chk = 0;
    int n_err = 0;
    int unit_lat = 1;

    ex_multicycle_seq #(.TIMEOUT(16)) dut (
        .clk         (clk),
        .reset       (reset),
        .instr_valid (instr_valid),
        .ID_EX_Instr (ID_EX_Instr),
        .op_a        (op_a),
        .op_b        (op_b),
        .stall       (stall),
        .mc_start    (mc_start),
        .mc_op       (mc_op),
        .mc_width    (mc_width),
        .mc_a        (mc_a),
        .mc_b        (mc_b),
        .mc_done     (mc_done),
        .mc_result   (mc_result),
        .seq_valid   (seq_valid),
        .seq_result  (seq_result),
        .dz_flag     (dz_flag),
        .to_flag     (to_flag)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mk(input logic [5:0] opc,
                                       input logic [1:0] ww,
                                       input logic [5:0] fn);
        return {opc, 18'd0, ww, fn};
    endfunction

    function automatic logic [63:0] isqrt(input logic [63:0] x);
        logic [63:0] r;
        logic [63:0] c;
        r = 64'd0;
        for (int i = 31; i >= 0; i--) begin
            c = r | (64'd1 << i);
            if (c * c <= x) r = c;
        end
        return r;
    endfunction

    function automatic logic [63:0] wmask(input logic [1:0] ww);
        case (ww)
            2'b00:   return 64'h0000_0000_0000_00ff;
            2'b01:   return 64'h0000_0000_0000_ffff;
            2'b10:   return 64'h0000_0000_ffff_ffff;
            default: return 64'hffff_ffff_ffff_ffff;
        endcase
    endfunction

    // Iterative unit: done unit_lat cycles after start, junk above the lane
    logic [1:0]  u_op;
    logic [1:0]  u_w;
    logic [63:0] u_a;
    logic [63:0] u_b;
    logic [63:0] u_r;
    int          pend = 0;

    always @(negedge clk) begin
        mc_done = 1'b0;
        if (pend > 0) begin
            pend = pend - 1;
            if (pend == 0) begin
                case (u_op)
                    2'b00:   u_r = (u_b == 0) ? 64'hffff_ffff_ffff_ffff : u_a / u_b;
                    2'b01:   u_r = (u_b == 0) ? u_a : u_a % u_b;
                    default: u_r = isqrt(u_a);
                endcase
                mc_result = (u_r & wmask(u_w)) | ~wmask(u_w);
                mc_done   = 1'b1;
            end
        end
        if (mc_start) begin
            u_op = mc_op;
            u_w  = mc_width;
            u_a  = mc_a;
            u_b  = mc_b;
            pend = unit_lat;
        end
    end

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic do_op(input vec_t v, output logic got,
                         output logic [63:0] res, output int starts,
                         output logic dz, output logic to, output int cyc,
                         output logic stall_ok, output logic [1:0] op_seen,
                         output logic [1:0] ww_seen);
        got = 0; res = 0; starts = 0; dz = 0; to = 0; cyc = 0;
        stall_ok = 1; op_seen = 0; ww_seen = 0;
        unit_lat    = v.lat;
        ID_EX_Instr = v.instr;
        op_a        = v.a;
        op_b        = v.b;
        instr_valid = 1'b1;
        while (!got && cyc < 300) begin
            @(negedge clk);
            cyc++;
            if (mc_start) begin
                starts++;
                if (starts == 1) begin
                    op_seen = mc_op;
                    ww_seen = mc_width;
                end
            end
            if (seq_valid) begin
                got = 1;
                res = seq_result;
                dz  = dz_flag;
                to  = to_flag;
                if (stall) stall_ok = 0;
            end else begin
                if (!stall) stall_ok = 0;
                @(posedge clk);
                #1;
                instr_valid = 1'b0;
            end
        end
        instr_valid = 1'b0;
    endtask

    task automatic quiet_run(input string name, input logic [31:0] ins,
                             input logic v);
        logic bad;
        bad = 1'b0;
        ID_EX_Instr = ins;
        op_a        = 64'd100;
        op_b        = 64'd7;
        instr_valid = v;
        repeat (4) begin
            @(negedge clk);
            if (stall || mc_start || seq_valid) bad = 1'b1;
            @(posedge clk);
            #1;
        end
        instr_valid = 1'b0;
        chk(name, {63'd0, bad}, 64'd0);
    endtask

    vec_t        vecs [8];
    logic        got;
    logic [63:0] res;
    int          starts;
    logic        dz;
    logic        to;
    int          cyc;
    logic        stall_ok;
    logic [1:0]  op_seen;
    logic [1:0]  ww_seen;
    logic        bad;

    initial begin
        vecs[0] = '{mk(OPC_V, 2'b11, F_DIV), 64'd100, 64'd7, 1,
                    64'd14, 1, 1'b0, 1'b0, 5, 2'b00};
        vecs[1] = '{mk(OPC_V, 2'b00, F_MOD), 64'h0B0B_0B0B_0B0B_0B0B,
                    64'h0300_0503_0702_0904, 2,
                    64'h020B_0102_0401_0203, 7, 1'b1, 1'b0, 32, 2'b01};
        vecs[2] = '{mk(OPC_V, 2'b10, F_SQRT), {32'd1000000, 32'd17}, 64'd0, 3,
                    {32'd1000, 32'd4}, 2, 1'b0, 1'b0, 12, 2'b10};
        vecs[3] = '{mk(OPC_V, 2'b01, F_DIV), 64'h03E8_FFFF_0009_0000,
                    64'h0007_0100_000A_0000, 1,
                    64'h008E_00FF_0000_FFFF, 3, 1'b1, 1'b0, 13, 2'b00};
        vecs[4] = '{mk(OPC_V, 2'b11, F_MOD), 64'hDEAD_BEEF_1234_5678, 64'd0, 1,
                    64'hDEAD_BEEF_1234_5678, 0, 1'b1, 1'b0, 4, 2'b01};
        vecs[5] = '{mk(OPC_V, 2'b11, F_SQRT), 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 2,
                    64'h0000_0000_FFFF_FFFF, 1, 1'b0, 1'b0, 6, 2'b10};
        vecs[6] = '{mk(OPC_V, 2'b10, F_DIV), {32'd100, 32'd5}, 64'd0, 1,
                    64'hFFFF_FFFF_FFFF_FFFF, 0, 1'b1, 1'b0, 6, 2'b00};
        vecs[7] = '{mk(OPC_V, 2'b11, F_DIV), 64'd5, 64'd1, 0,
                    64'hFFFF_FFFF_FFFF_FFFF, 1, 1'b0, 1'b1, 20, 2'b00};

        reset       = 1'b1;
        instr_valid = 1'b0;
        ID_EX_Instr = 32'd0;
        op_a        = 64'd0;
        op_b        = 64'd0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        @(negedge clk);
        chk("rst_stall", {63'd0, stall}, 64'd0);
        chk("rst_start", {63'd0, mc_start}, 64'd0);
        chk("rst_valid", {63'd0, seq_valid}, 64'd0);
        chk("rst_result", seq_result, 64'd0);
        chk("rst_lanes", mc_a | mc_b, 64'd0);
        chk("rst_flags", {62'd0, dz_flag, to_flag}, 64'd0);
        @(posedge clk);
        #1;

        quiet_run("vadd_quiet", mk(OPC_V, 2'b11, 6'b000001), 1'b1);
        quiet_run("load_quiet", mk(6'b100011, 2'b11, F_DIV), 1'b1);
        quiet_run("novalid_quiet", mk(OPC_V, 2'b11, F_DIV), 1'b0);

        // Each vector starts in the IDLE cycle right after the previous DONE
        for (int i = 0; i < 8; i++) begin
            do_op(vecs[i], got, res, starts, dz, to, cyc, stall_ok,
                  op_seen, ww_seen);
            chk($sformatf("v%0d_done", i), {63'd0, got}, 64'd1);
            chk($sformatf("v%0d_result", i), res, vecs[i].exp_res);
            chk($sformatf("v%0d_starts", i), 64'(starts), 64'(vecs[i].exp_starts));
            chk($sformatf("v%0d_dz", i), {63'd0, dz}, {63'd0, vecs[i].exp_dz});
            chk($sformatf("v%0d_to", i), {63'd0, to}, {63'd0, vecs[i].exp_to});
            chk($sformatf("v%0d_cycles", i), 64'(cyc), 64'(vecs[i].exp_cyc));
            chk($sformatf("v%0d_stall", i), {63'd0, stall_ok}, 64'd1);
            if (vecs[i].exp_starts > 0) begin
                chk($sformatf("v%0d_op", i), {62'd0, op_seen}, {62'd0, vecs[i].exp_op});
                chk($sformatf("v%0d_width", i), {62'd0, ww_seen},
                    {62'd0, vecs[i].instr[7:6]});
            end
            @(posedge clk);
            #1;
        end

        // Reset during lane 2 WAIT of a 4-lane VDIV
        unit_lat    = 6;
        ID_EX_Instr = mk(OPC_V, 2'b01, F_DIV);
        op_a        = 64'h0064_0064_0064_0064;
        op_b        = 64'h0005_0005_0005_0005;
        instr_valid = 1'b1;
        starts      = 0;
        cyc         = 0;
        while (starts < 3 && cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (mc_start) starts++;
            if (starts < 3) begin
                @(posedge clk);
                #1;
                instr_valid = 1'b0;
            end
        end
        chk("rst_mid_lane2", 64'(starts), 64'd3);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("rst_mid_stall", {63'd0, stall}, 64'd0);
        chk("rst_mid_start", {63'd0, mc_start}, 64'd0);
        chk("rst_mid_valid", {63'd0, seq_valid}, 64'd0);
        chk("rst_mid_result", seq_result, 64'd0);
        chk("rst_mid_lanes", mc_a | mc_b | {60'd0, mc_op, mc_width}, 64'd0);
        bad = 1'b0;
        repeat (12) begin
            @(posedge clk);
            #1;
            @(negedge clk);
            if (stall || mc_start || seq_valid) bad = 1'b1;
        end
        chk("rst_late_done", {63'd0, bad}, 64'd0);
        chk("rst_late_result", seq_result, 64'd0);
        chk("rst_late_flags", {62'd0, dz_flag, to_flag}, 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
